// File: rtl/port_arbiter.sv
// port_arbiter: three-requester memory port arbiter, fixed priority IC > MVU > Ctrl, with burst lock and lock timeout.
// Define PORT_ARBITER_AGING_EN to add MVU/Ctrl wait counters that override priority once starved.
module port_arbiter #(
  parameter int A       = 9,
  parameter int W       = 128,
  parameter int MAXLOCK = 16,
  parameter int MAXWAIT = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         reqIC,
  input  logic         reqMVU,
  input  logic         reqCtrl,
  input  logic         lockIC,
  input  logic         lockMVU,
  input  logic         lockCtrl,
  input  logic         weIC,
  input  logic         weMVU,
  input  logic         weCtrl,
  input  logic [A-1:0] addrIC,
  input  logic [A-1:0] addrMVU,
  input  logic [A-1:0] addrCtrl,
  input  logic [W-1:0] dataIC,
  input  logic [W-1:0] dataMVU,
  input  logic [W-1:0] dataCtrl,
  output logic         grntIC,
  output logic         grntMVU,
  output logic         grntCtrl,
  output logic         en,
  output logic         we,
  output logic [A-1:0] addr,
  output logic [W-1:0] data
);
  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;
  localparam int LW = $clog2(MAXLOCK + 1);
  localparam logic [LW-1:0] LMAX = LW'(MAXLOCK);
  state_t        r_state, w_next;
  logic [2:0]    r_grnt, w_win, w_req, w_lock, w_wev, w_elig, w_aged;
  logic [LW-1:0] r_lock_cnt, w_lock_cnt;
  logic          w_owner_hold, w_keep, w_force, w_we, r_we;
  logic [A-1:0]  w_addr, r_addr;
  logic [W-1:0]  w_data, r_data;
  assign w_req  = {reqCtrl, reqMVU, reqIC};
  assign w_lock = {lockCtrl, lockMVU, lockIC};
  assign w_wev  = {weCtrl, weMVU, weIC};
  // The current grant vector doubles as the lock owner.
  assign w_owner_hold = (r_state == LOCKED) && |(r_grnt & w_req & w_lock);
  assign w_keep       = w_owner_hold && (r_lock_cnt < LMAX);
  assign w_force      = w_owner_hold && (r_lock_cnt >= LMAX);
  assign w_elig       = w_req & ~(w_force ? r_grnt : 3'b000);
`ifdef PORT_ARBITER_AGING_EN
  localparam int CW = $clog2(MAXWAIT + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAXWAIT);
  logic [CW-1:0] r_wait_mvu, r_wait_ctrl;
  assign w_aged = w_elig & {r_wait_ctrl >= CMAX, r_wait_mvu >= CMAX, 1'b0};
  // Counters saturate at the threshold and clear as soon as their owner wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_mvu  <= '0;
      r_wait_ctrl <= '0;
    end else begin
      r_wait_mvu  <= (reqMVU && !w_win[1]) ? r_wait_mvu + CW'(r_wait_mvu < CMAX) : '0;
      r_wait_ctrl <= (reqCtrl && !w_win[2]) ? r_wait_ctrl + CW'(r_wait_ctrl < CMAX) : '0;
    end
  end
`else
  assign w_aged = 3'b000;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_grnt     <= '0;
      r_lock_cnt <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_state    <= w_next;
      r_grnt     <= w_win;
      r_lock_cnt <= w_lock_cnt;
      r_we       <= w_we;
      r_addr     <= w_addr;
      r_data     <= w_data;
    end
  end
  always_comb begin
    w_win  = w_keep     ? r_grnt :
             w_aged[2]  ? 3'b100 :
             w_aged[1]  ? 3'b010 :
             w_elig[0]  ? 3'b001 :
             w_elig[1]  ? 3'b010 :
             w_elig[2]  ? 3'b100 : 3'b000;
    w_next = !(|w_win) ? IDLE : |(w_win & w_lock) ? LOCKED : GRANT;
  end
  always_comb begin
    w_lock_cnt = w_keep ? r_lock_cnt + LW'(1) : (w_next == LOCKED) ? LW'(1) : '0;
    w_we       = |(w_win & w_wev);
    w_addr     = w_win[0] ? addrIC : w_win[1] ? addrMVU : w_win[2] ? addrCtrl : r_addr;
    w_data     = w_win[0] ? dataIC : w_win[1] ? dataMVU : w_win[2] ? dataCtrl : r_data;
  end
  assign {grntCtrl, grntMVU, grntIC} = r_grnt;
  assign en   = |r_grnt;
  assign we   = r_we;
  assign addr = r_addr;
  assign data = r_data;
endmodule
